// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Perf counters are compiled in with FETCH_PERF_CNT_EN.
package fetch_pkg;
  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 32;
  localparam int PC_STEP_DEF = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Decoupling FIFO of fetched {pc, instr} entries.
// Flush empties it in one edge; the head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  assign head = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC register, IM address, FIFO and decode handshake.
// FETCH_PERF_CNT_EN adds stall_cycles and flush_count outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = PC_STEP_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CW-1:0]     count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  logic [ADDR_W-1:0] pc;
  logic full;
  logic push;
  logic pop;
  fetch_entry_t wdata;
  fetch_entry_t head;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0) & ~redirect;
  assign pop       = out_valid & out_ready;
  // Pop frees a slot the same edge, so a full FIFO still accepts a fetch.
  assign push      = ~redirect & (~full | pop);

  assign wdata.pc    = pc;
  assign wdata.instr = instr_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect)
      pc <= redirect_pc;
    else if (push)
      pc <= pc + ADDR_W'(PC_STEP);
  end

  assign instr_addr = pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (full && !pop && !redirect && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (redirect && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, random run against a queue model,
// async reset and PC wrap sequences.
module tb_fetch_stage;

  localparam int D0 = 4;
  localparam int D1 = 2;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  logic [31:0] addr0, instr0, rpc, opc0, oin0;
  logic        rd, rdy, vld0;
  logic [2:0]  cnt0;

  logic [31:0] addr1, instr1, opc1, oin1;
  logic        vld1;
  logic [1:0]  cnt1;

  assign instr0 = im(addr0);
  assign instr1 = im(addr1);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall0, flush0, stall1, flush1;
`endif

  fetch_stage #(.DEPTH(D0), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .rst(rst), .instr_addr(addr0), .instr_in(instr0),
    .redirect(rd), .redirect_pc(rpc), .out_valid(vld0),
    .out_ready(rdy), .out_instr(oin0), .out_pc(opc0), .count(cnt0)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall0), .flush_count(flush0)
`endif
  );

  fetch_stage #(.DEPTH(D1), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .instr_addr(addr1), .instr_in(instr1),
    .redirect(1'b0), .redirect_pc(32'h0), .out_valid(vld1),
    .out_ready(1'b1), .out_instr(oin1), .out_pc(opc1), .count(cnt1)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall1), .flush_count(flush1)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        vld;
    logic [31:0] pc;
    int          cnt;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[13];

  logic [31:0] qpc[$];
  logic [31:0] qin[$];
  logic [31:0] mpc;
  int m_stall, m_flush;
  int thr;

  task automatic model_reset(input logic [31:0] rpc_v);
    qpc.delete();
    qin.delete();
    mpc = rpc_v;
    m_stall = 0;
    m_flush = 0;
  endtask

  initial begin
    tbl[0]  = '{0, 0,      1, 0, 32'h0,   0, 32'h0};
    tbl[1]  = '{0, 0,      1, 1, 32'h0,   1, 32'h4};
    tbl[2]  = '{0, 0,      1, 1, 32'h4,   1, 32'h8};
    tbl[3]  = '{0, 0,      0, 1, 32'h8,   1, 32'hC};
    tbl[4]  = '{0, 0,      0, 1, 32'h8,   2, 32'h10};
    tbl[5]  = '{0, 0,      0, 1, 32'h8,   3, 32'h14};
    tbl[6]  = '{0, 0,      0, 1, 32'h8,   4, 32'h18};
    tbl[7]  = '{0, 0,      0, 1, 32'h8,   4, 32'h18};
    tbl[8]  = '{0, 0,      1, 1, 32'h8,   4, 32'h18};
    tbl[9]  = '{0, 0,      1, 1, 32'hC,   4, 32'h1C};
    tbl[10] = '{1, 32'h100, 1, 0, 32'h10, 4, 32'h20};
    tbl[11] = '{0, 0,      1, 0, 32'h0,   0, 32'h100};
    tbl[12] = '{0, 0,      1, 1, 32'h100, 1, 32'h104};

    rd = 0; rpc = 0; rdy = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_vld", 32'(vld0), 0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_pc", opc0, 0);
    chk("rst_instr", oin0, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 13; i++) begin
      rd = tbl[i].rd; rpc = tbl[i].rpc; rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_vld", i), 32'(vld0), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_addr", i), addr0, tbl[i].addr);
      chk($sformatf("tbl%0d_pc", i), opc0, tbl[i].cnt == 0 ? 0 : tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), oin0,
          tbl[i].cnt == 0 ? 0 : im(tbl[i].pc));
      @(negedge clk);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("tbl_stall", stall0, 2);
    chk("tbl_flush", flush0, 1);
`endif

    rd = 0; rdy = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset(32'h0);
    thr = 2;
    for (int c = 0; c < 400; c++) begin
      logic v;
      if (c % 50 == 0) thr = $urandom_range(0, 4);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = {$urandom_range(0, 32'hFFFF), 14'h0, 2'b00};
      rdy = ($urandom_range(0, 3) < thr);
      #1;
      v = (qpc.size() != 0) && !rd;
      chk("rnd_vld", 32'(vld0), 32'(v));
      chk("rnd_cnt", 32'(cnt0), qpc.size());
      chk("rnd_addr", addr0, mpc);
      chk("rnd_pc", opc0, qpc.size() != 0 ? qpc[0] : 0);
      chk("rnd_instr", oin0, qin.size() != 0 ? qin[0] : 0);
`ifdef FETCH_PERF_CNT_EN
      chk("rnd_stall", stall0, m_stall);
      chk("rnd_flush", flush0, m_flush);
`endif
      if (rd) begin
        qpc.delete();
        qin.delete();
        mpc = rpc;
        m_flush++;
      end else begin
        if (qpc.size() == D0 && !(v && rdy)) m_stall++;
        if (v && rdy) begin
          void'(qpc.pop_front());
          void'(qin.pop_front());
        end
        if (qpc.size() < D0) begin
          qpc.push_back(mpc);
          qin.push_back(im(mpc));
          mpc = mpc + 4;
        end
      end
      @(negedge clk);
    end

    rd = 0; rdy = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_cnt", 32'(cnt0), D0);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("arst_vld", 32'(vld0), 0);
    chk("arst_cnt", 32'(cnt0), 0);
    chk("arst_addr", addr0, 32'h0);
    chk("arst_addr1", addr1, 32'hFFFF_FFF8);
    chk("arst_vld1", 32'(vld1), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_stall", stall0, 0);
    chk("arst_flush", flush0, 0);
`endif
    @(negedge clk);
    rst = 0;
    #1;
    chk("wrap_cnt0", 32'(cnt1), 0);
    for (int k = 1; k <= 4; k++) begin
      logic [31:0] e;
      @(negedge clk);
      #1;
      e = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
      chk($sformatf("wrap%0d_vld", k), 32'(vld1), 1);
      chk($sformatf("wrap%0d_pc", k), opc1, e);
      chk($sformatf("wrap%0d_instr", k), oin1, im(e));
      chk($sformatf("wrap%0d_addr", k), addr1, e + 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
